stream_unpack: RTL

- Wide-to-narrow stream serializer. Accepts one word of Ratio*OutBits bits per valid/ready handshake and emits it as in_count narrow beats on a valid/ready output.
- Packet framing is carried on a last flag.
- Sits downstream of wide-datapath blocks, such as the trace capture RAM read side, and ahead of narrow links.
- It is the counterpart of the narrow-to-wide packer.
- out_data, out_valid and out_last are registered.

---
 rtl/stream_unpack_if.sv | 27 ++
 rtl/stream_unpack.sv | 102 ++++++++++
 2 files changed

// File: rtl/stream_unpack_if.sv
// Wide-word in / narrow-beat out handshake bundle for stream_unpack.
// The slave modport is the serializer's view; master is the view of the surrounding logic.
interface stream_unpack_if #(
    parameter int OutBits = 8,
    parameter int Ratio   = 4,
    parameter int CntBits = $clog2(Ratio + 1)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OutBits*Ratio-1:0] in_data;
    logic [CntBits-1:0]       in_count;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [OutBits-1:0]       out_data;
    logic                     out_last;

    modport slave (
        input  in_valid, in_data, in_count, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_unpack.sv
// Wide-to-narrow stream serializer: one Ratio*OutBits word per input handshake,
// emitted as in_count registered OutBits beats with packet last on the final beat.
module stream_unpack #(
    parameter int OutBits  = 8,
    parameter int Ratio    = 4,
    parameter bit MsbFirst = 1'b0,
    parameter int CntBits  = $clog2(Ratio + 1)
) (
    input logic          clk,
    input logic          rst,
    stream_unpack_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [Ratio-1:0][OutBits-1:0] word_t;

    localparam logic [CntBits-1:0] CntFull = CntBits'(Ratio);
    localparam logic [CntBits-1:0] CntOne  = CntBits'(1);
    localparam logic [CntBits-1:0] CntTwo  = CntBits'(2);

    generate
        if (Ratio < 2) begin : g_bad_ratio
            $error("stream_unpack: Ratio must be >= 2");
        end
    endgenerate

    state_t             state;
    word_t              sreg;
    word_t              in_word;
    word_t              ld_rest;
    word_t              nx_rest;
    logic [OutBits-1:0] ld_beat;
    logic [OutBits-1:0] nx_beat;
    logic [OutBits-1:0] out_data;
    logic [CntBits-1:0] rem;
    logic [CntBits-1:0] in_cnt;
    logic               last_q;
    logic               out_valid;
    logic               out_last;
    logic               in_ready;
    logic               accept;

    assign in_word = word_t'(bus.in_data);

    // Zero means a full word; out-of-range counts are clamped to a full word.
    assign in_cnt = (bus.in_count == '0 || bus.in_count > CntFull) ? CntFull : bus.in_count;

    // The register holds only the beats not yet presented; out_data holds the current one.
    always_comb begin
        if (MsbFirst) begin
            ld_beat = in_word[Ratio-1];
            ld_rest = in_word << OutBits;
            nx_beat = sreg[Ratio-1];
            nx_rest = sreg << OutBits;
        end else begin
            ld_beat = in_word[0];
            ld_rest = in_word >> OutBits;
            nx_beat = sreg[0];
            nx_rest = sreg >> OutBits;
        end
    end

    // Ready flows straight from out_ready on the final beat so words chain without a bubble.
    assign in_ready = (state == IDLE) || (bus.out_ready && rem == CntOne);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            rem       <= '0;
            last_q    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            state     <= SEND;
            sreg      <= ld_rest;
            rem       <= in_cnt;
            last_q    <= bus.in_last;
            out_data  <= ld_beat;
            out_valid <= 1'b1;
            out_last  <= bus.in_last && (in_cnt == CntOne);
        end else if (state == SEND && bus.out_ready) begin
            if (rem != CntOne) begin
                sreg     <= nx_rest;
                rem      <= rem - CntOne;
                out_data <= nx_beat;
                out_last <= last_q && (rem == CntTwo);
            end else begin
                state     <= IDLE;
                rem       <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
endmodule
